// File: rtl/timebase_pkg.sv
// Shared constants and types for the multi-channel timebase.
// Default dividers give a 1 Hz tick at 100 MHz, or a tick every 10 cycles in test mode.
package timebase_pkg;

  localparam int DIV_NORM_DEF = 99_999_999;
  localparam int DIV_TEST_DEF = 9;
  localparam int CNT_W_DEF    = 8;

  typedef logic [CNT_W_DEF-1:0] cnt_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_t;

endpackage

// File: rtl/timebase_channel.sv
// One loadable countdown channel: decrements on t_int while running, pulses done on expiry.
// Load to busy is 1 cycle; done is registered and coincides with busy falling.
module timebase_channel
  import timebase_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             ld,
  input  logic [CNT_W-1:0] ld_val,
  input  logic             t_int,
  output logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             done
);

  ch_state_t state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else if (ld) begin
      // A load always wins over a coincident tick; a zero load expires at once.
      if (ld_val != '0) begin
        state <= RUN;
        cnt   <= ld_val;
        done  <= 1'b0;
      end else begin
        state <= IDLE;
        cnt   <= '0;
        done  <= 1'b1;
      end
    end else if (t_int && (state == RUN)) begin
      cnt <= cnt - 1'b1;
      if (cnt == CNT_W'(1)) begin
        state <= IDLE;
        done  <= 1'b1;
      end else begin
        done  <= 1'b0;
      end
    end else begin
      done <= 1'b0;
    end
  end

  assign busy = (state == RUN);

endmodule

// File: rtl/timebase_multi_timer.sv
// Shared prescaler producing a one-cycle tick every div+1 enabled cycles, driving N_CH countdown channels.
// tick and channel updates land on the same edge; enable=0 freezes everything without losing phase.
module timebase_multi_timer
  import timebase_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int PRE_W    = 28,
  parameter int DIV_NORM = DIV_NORM_DEF,
  parameter int DIV_TEST = DIV_TEST_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  testmode,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [N_CH-1:0]       ld,
  input  logic [N_CH*CNT_W-1:0] ld_val,
  output logic                  tick,
  output logic [N_CH*CNT_W-1:0] cnt,
  output logic [N_CH-1:0]       busy,
  output logic [N_CH-1:0]       done
);

  localparam logic [PRE_W-1:0] DIV_N = PRE_W'(DIV_NORM);
  localparam logic [PRE_W-1:0] DIV_T = PRE_W'(DIV_TEST);

  logic [PRE_W-1:0] q;
  logic [PRE_W-1:0] div;
  logic             tm_q;
  logic             mode_chg;
  logic             t_int;

  assign div      = tm_q ? DIV_T : DIV_N;
  assign mode_chg = (testmode != tm_q);
  // A mode switch restarts the period, so it must suppress the strobe that cycle.
  assign t_int    = enable && (q == div) && !mode_chg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q    <= '0;
      tm_q <= 1'b0;
      tick <= 1'b0;
    end else begin
      tm_q <= testmode;
      if (clear || mode_chg) begin
        q    <= '0;
        tick <= 1'b0;
      end else if (t_int) begin
        q    <= '0;
        tick <= 1'b1;
      end else begin
        tick <= 1'b0;
        if (enable) begin
          q <= q + 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    timebase_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .ld    (ld[i]),
      .ld_val(ld_val[i*CNT_W +: CNT_W]),
      .t_int (t_int),
      .cnt   (cnt[i*CNT_W +: CNT_W]),
      .busy  (busy[i]),
      .done  (done[i])
    );
  end

endmodule

// File: tb/tb_timebase_multi_timer.sv
// Directed bench for timebase_multi_timer with DIV_TEST=9 and DIV_NORM shortened to 99.
module tb_timebase_multi_timer;

  localparam int N_CH  = 4;
  localparam int CNT_W = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  testmode;
  logic                  enable;
  logic                  clear;
  logic [N_CH-1:0]       ld;
  logic [N_CH*CNT_W-1:0] ld_val;
  logic                  tick;
  logic [N_CH*CNT_W-1:0] cnt;
  logic [N_CH-1:0]       busy;
  logic [N_CH-1:0]       done;

  int checks = 0;
  int passed = 0;

  timebase_multi_timer #(
    .N_CH    (N_CH),
    .CNT_W   (CNT_W),
    .PRE_W   (28),
    .DIV_NORM(99),
    .DIV_TEST(9)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .testmode(testmode),
    .enable  (enable),
    .clear   (clear),
    .ld      (ld),
    .ld_val  (ld_val),
    .tick    (tick),
    .cnt     (cnt),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CNT_W-1:0] cnt_of(input int i);
    return cnt[i*CNT_W +: CNT_W];
  endfunction

  task automatic wait_tick(input int bound, output bit seen);
    int k;
    k = 0;
    seen = 1'b0;
    while (!seen && k < bound) begin
      cyc();
      k++;
      seen = tick;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; testmode = 1'b1; enable = 1'b0; clear = 1'b0; ld = '0; ld_val = '0;
    repeat (3) cyc();
    checks++;
    if ({tick, cnt, busy, done} !== '0)
      $display("FAIL reset_outputs: got tick=%b cnt=%h busy=%b done=%b, want all 0", tick, cnt, busy, done);
    else passed++;
    rst = 1'b1;
    repeat (3) cyc();
    checks++;
    if ({tick, busy, done} !== '0)
      $display("FAIL idle_after_release: got tick=%b busy=%b done=%b, want all 0", tick, busy, done);
    else passed++;
  endtask

  task automatic test_tick_period();
    int n;
    enable = 1'b1;
    for (int p = 0; p < 3; p++) begin
      n = 0;
      repeat (9) begin
        cyc();
        if (tick) n++;
      end
      checks++;
      if (n !== 0) $display("FAIL tick_gap[%0d]: got %0d ticks in 9 cycles, want 0", p, n);
      else passed++;
      cyc();
      checks++;
      if (tick !== 1'b1) $display("FAIL tick_on_10th[%0d]: got tick=%b, want 1", p, tick);
      else passed++;
    end
  endtask

  task automatic test_load_countdown();
    int dn;
    logic [CNT_W-1:0] c9, c19;
    dn = 0; c9 = '0; c19 = '0;
    ld = 4'b0001; ld_val = '0; ld_val[7:0] = 8'd3;
    cyc();
    ld = '0;
    checks++;
    if (busy[0] !== 1'b1 || cnt_of(0) !== 8'd3)
      $display("FAIL load_ch0: got busy=%b cnt=%0d, want busy=1 cnt=3", busy[0], cnt_of(0));
    else passed++;
    for (int k = 1; k <= 29; k++) begin
      cyc();
      if (k < 29 && done[0]) dn++;
      if (k == 9)  c9  = cnt_of(0);
      if (k == 19) c19 = cnt_of(0);
    end
    checks++;
    if (c9 !== 8'd2 || c19 !== 8'd1)
      $display("FAIL countdown_ch0: got cnt %0d,%0d at ticks 1,2, want 2,1", c9, c19);
    else passed++;
    checks++;
    if (dn !== 0) $display("FAIL early_done_ch0: got %0d done pulses before expiry, want 0", dn);
    else passed++;
    checks++;
    if (done[0] !== 1'b1 || busy[0] !== 1'b0 || cnt_of(0) !== 8'd0)
      $display("FAIL expire_ch0: got done=%b busy=%b cnt=%0d, want 1 0 0", done[0], busy[0], cnt_of(0));
    else passed++;
    cyc();
    checks++;
    if (done[0] !== 1'b0) $display("FAIL done_width_ch0: got done=%b, want 0", done[0]);
    else passed++;
  endtask

  task automatic test_load_zero();
    ld = 4'b0010; ld_val = '0;
    cyc();
    ld = '0;
    checks++;
    if (busy[1] !== 1'b0 || done[1] !== 1'b1 || cnt_of(1) !== 8'd0)
      $display("FAIL load_zero_ch1: got busy=%b done=%b cnt=%0d, want 0 1 0", busy[1], done[1], cnt_of(1));
    else passed++;
    cyc();
    checks++;
    if (done[1] !== 1'b0) $display("FAIL load_zero_width_ch1: got done=%b, want 0", done[1]);
    else passed++;
  endtask

  task automatic test_reload_on_tick();
    bit seen;
    int n;
    wait_tick(20, seen);
    checks++;
    if (!seen) $display("FAIL reload_sync_tick: got no tick in 20 cycles, want a tick");
    else passed++;
    ld = 4'b0100; ld_val = '0; ld_val[23:16] = 8'd5;
    cyc();
    ld = '0;
    checks++;
    if (cnt_of(2) !== 8'd5 || busy[2] !== 1'b1)
      $display("FAIL load_ch2: got cnt=%0d busy=%b, want 5 1", cnt_of(2), busy[2]);
    else passed++;
    repeat (8) cyc();
    ld = 4'b0100; ld_val[23:16] = 8'd7;
    cyc();
    ld = '0;
    checks++;
    if (tick !== 1'b1) $display("FAIL reload_coincident_tick: got tick=%b, want 1", tick);
    else passed++;
    checks++;
    if (cnt_of(2) !== 8'd7 || busy[2] !== 1'b1 || done[2] !== 1'b0)
      $display("FAIL reload_ch2: got cnt=%0d busy=%b done=%b, want 7 1 0", cnt_of(2), busy[2], done[2]);
    else passed++;
    repeat (9) cyc();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    checks++;
    if (tick !== 1'b0 || cnt !== '0 || busy !== '0 || done !== '0)
      $display("FAIL clear: got tick=%b cnt=%h busy=%b done=%b, want all 0", tick, cnt, busy, done);
    else passed++;
    n = 0;
    repeat (9) begin
      cyc();
      if (tick) n++;
    end
    cyc();
    checks++;
    if (n !== 0 || tick !== 1'b1)
      $display("FAIL period_after_clear: got %0d early ticks and tick=%b on 10th, want 0 and 1", n, tick);
    else passed++;
  endtask

  task automatic test_enable_freeze();
    int n;
    ld = 4'b1000; ld_val = '0; ld_val[31:24] = 8'd2;
    cyc();
    ld = '0;
    repeat (3) cyc();
    enable = 1'b0;
    n = 0;
    repeat (25) begin
      cyc();
      if (tick) n++;
    end
    checks++;
    if (n !== 0 || cnt_of(3) !== 8'd2 || busy[3] !== 1'b1)
      $display("FAIL freeze: got %0d ticks cnt=%0d busy=%b, want 0 ticks cnt=2 busy=1", n, cnt_of(3), busy[3]);
    else passed++;
    enable = 1'b1;
    n = 0;
    repeat (5) begin
      cyc();
      if (tick) n++;
    end
    cyc();
    checks++;
    if (n !== 0 || tick !== 1'b1)
      $display("FAIL resume: got %0d early ticks and tick=%b on 6th, want 0 and 1", n, tick);
    else passed++;
    checks++;
    if (cnt_of(3) !== 8'd1) $display("FAIL resume_ch3: got cnt=%0d, want 1", cnt_of(3));
    else passed++;
  endtask

  task automatic test_mode_change();
    int n;
    repeat (5) cyc();
    testmode = 1'b0;
    n = 0;
    repeat (100) begin
      cyc();
      if (tick) n++;
    end
    checks++;
    if (n !== 0) $display("FAIL mode_change_gap: got %0d ticks in 100 cycles, want 0", n);
    else passed++;
    cyc();
    checks++;
    if (tick !== 1'b1) $display("FAIL mode_change_tick: got tick=%b, want 1", tick);
    else passed++;
    checks++;
    if (done[3] !== 1'b1 || busy[3] !== 1'b0)
      $display("FAIL expire_ch3: got done=%b busy=%b, want 1 0", done[3], busy[3]);
    else passed++;
  endtask

  task automatic test_reset_midcount();
    int n;
    ld = 4'b0001; ld_val = '0; ld_val[7:0] = 8'd9;
    cyc();
    ld = '0;
    repeat (10) cyc();
    checks++;
    if (busy[0] !== 1'b1) $display("FAIL pre_reset_busy: got busy=%b, want 1", busy[0]);
    else passed++;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({tick, cnt, busy, done} !== '0)
      $display("FAIL async_reset: got tick=%b cnt=%h busy=%b done=%b, want all 0", tick, cnt, busy, done);
    else passed++;
    repeat (2) cyc();
    rst = 1'b1;
    n = 0;
    repeat (99) begin
      cyc();
      if (tick) n++;
    end
    cyc();
    checks++;
    if (n !== 0 || tick !== 1'b1)
      $display("FAIL first_tick_after_reset: got %0d early ticks and tick=%b on 100th, want 0 and 1", n, tick);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_tick_period();
    test_load_countdown();
    test_load_zero();
    test_reload_on_tick();
    test_enable_freeze();
    test_mode_change();
    test_reset_midcount();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/timebase_multi_timer.md
# timebase_multi_timer

- Parametrised successor to the single-output timebase divider.
- A shared prescaler produces a one-cycle `tick` at a mode-selected period: normal or test.
- The tick drives N independent loadable countdown timers. Each timer reports `busy`, its current count and a one-cycle `done` pulse.
- Sits between the board clock and the traffic-light sequencer: the sequencer loads phase durations in ticks (seconds in normal mode) and waits for `done`.

## Interface
Parameters:
- `N_CH`, 4: number of countdown channels (1..16).
- `CNT_W`, 8: channel count width in ticks.
- `PRE_W`, 28: prescaler counter width.
- `DIV_NORM`, 99_999_999: normal terminal count; gives a 1 Hz tick at 100 MHz.
- `DIV_TEST`, 9: test-mode terminal count; gives a tick every 10 cycles.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `testmode`  in  1  1 = use `DIV_TEST`, 0 = use `DIV_NORM`. Level, synchronous to `clk`.
- `enable`  in  1  1 = prescaler runs; 0 = prescaler and all channels freeze.
- `clear`  in  1  synchronous clear of prescaler and all channels.
- `ld`  in  N_CH  per-channel load strobe.
- `ld_val`  in  N_CH*CNT_W  per-channel load value; channel i is at bits [i*CNT_W +: CNT_W].
- `tick`  out  1  one-cycle timebase pulse.
- `cnt`  out  N_CH*CNT_W  per-channel remaining count.
- `busy`  out  N_CH  channel counting.
- `done`  out  N_CH  one-cycle expiry pulse.

## Operation
- Reset (`rst`=0, asynchronous): all registers go to 0. That includes prescaler `q`, `tick`, `cnt`, `busy`, `done` and the registered testmode `tm_q`.
- Prescaler:
  - `div` = `tm_q` ? `DIV_TEST` : `DIV_NORM`.
  - The internal strobe `t_int` = `enable` && (`q` == `div`).
  - On `t_int`, `q` goes to 0. Else if `enable`, `q` increments. Else `q` holds.
  - Tick period is exactly `div`+1 cycles.
- Mode change: `tm_q` registers `testmode`. When `testmode` != `tm_q`, `q` goes to 0 and no `t_int` is generated that cycle. The new period is counted from that point.
- `clear`:
  - `q`, `tick`, `done` go to 0; all `cnt` and `busy` go to 0.
  - `clear` takes priority over `ld`, tick and mode change.
- Channel i, evaluated in priority order:
  1. `ld[i]` with value V>0: `cnt`=V, `busy`=1. Any pending tick that cycle is ignored for this channel.
  2. `ld[i]` with V=0: `cnt`=0, `busy`=0, `done[i]`=1 next cycle.
  3. `t_int` && `busy[i]`: `cnt` decrements. On a 1→0 transition, `busy` goes to 0 and `done[i]`=1 for one cycle.
  4. Otherwise hold.
- Reloading a busy channel restarts it with no `done` pulse.
- Arithmetic is unsigned. The decrement never goes below 0, because `busy`=0 at 0. `DIV_*` must be less than 2^`PRE_W`.

## Timing
- `tick` is a registered `t_int`. It is high for exactly one cycle, on the edge after `q`==`div`.
- A channel decrement lands on the same edge that raises `tick`. `cnt` and `tick` change together.
- Load to `busy` high: 1 cycle.
- Load of V: `done` pulses on the edge that raises the V-th subsequent `tick`. Elapsed time is between (V-1)·P+1 and V·P cycles, where P = `div`+1, depending on prescaler phase.
- `done` registered: high for one cycle, coincident with `busy` falling.
- `enable`=0 freezes `q` mid-count. Resuming continues from the held value, with no extra or lost tick.
- Reset asserted mid-count: outputs go to 0 immediately. After release, the first `tick` comes P cycles after the first enabled edge.

## Structure
- Package `timebase_pkg`:
  - `DIV_NORM_DEF` and `DIV_TEST_DEF` constants.
  - `cnt_t` typedef (`logic [CNT_W-1:0]` default 8).
  - `ch_state_t`: IDLE, RUN.
- Sub-module `timebase_channel`: one countdown channel with `ld`/`ld_val`/`t_int`/`clear` inputs and `cnt`/`busy`/`done` outputs. Instantiated `N_CH` times in a generate loop.
- Top level holds the prescaler, testmode register and tick register.

## Test plan
- `testmode`=1, `enable`=1, reset released: `tick` pulses every 10 cycles, each 1 cycle wide. No tick in the first 9 cycles.
- Test mode, load ch0 V=3 just after a tick: `busy[0]`=1 next cycle. `cnt` goes 3→2→1→0 on three ticks. `done[0]` is a single pulse at 30 cycles.
- Load ch1 V=0: `busy[1]` stays 0, `done[1]`=1 exactly one cycle later, `cnt`=0.
- ch2 busy at 5, assert `ld[2]` with V=7 coincident with a tick: `cnt`=7 with no decrement that cycle and no `done`. Pulse `clear` later: all `cnt`, `busy`, `tick` are 0 next cycle.
- `enable`=0 for 25 cycles at `q`=4: no `tick` and counts hold. After release, the next `tick` comes after 6 cycles.
- Toggle `testmode` 1→0 at `q`=5: `q` restarts. No tick for 100,000,000 cycles (run with `DIV_NORM` overridden to 99 in simulation: no tick for 100 cycles).
